// File: rtl/cnn_pkg.sv
// cnn_pkg: shared image/pixel defaults, address-width helper and the
// frame streamer state encoding.
package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 8;
  localparam int CNN_IN_CHANNEL = 3;
  localparam int CNN_IMG_WIDTH  = 32;
  localparam int CNN_IMG_HEIGHT = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOF    = 3'd1,
    ST_STREAM = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } streamer_state_t;

  // Bits needed to address 'depth' entries; never less than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// frame_ram: simple dual-port frame buffer, one write port and one read
// port with a single cycle of registered read latency. Contents are never
// reset.
module frame_ram
  import cnn_pkg::*;
#(
  parameter int WORDS  = CNN_IMG_WIDTH * CNN_IMG_HEIGHT,
  parameter int WIDTH  = CNN_IN_CHANNEL * CNN_DATA_WIDTH,
  parameter int ADDR_W = addr_w(WORDS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [WORDS];
  logic [WIDTH-1:0] r_rdata;

  // Write port: one word per strobe.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: data appears the cycle after the address is presented.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_streamer.sv
// frame_streamer: streams one stored frame in raster order on request.
// The read address is issued a cycle ahead of pixel_valid so the frame
// leaves without bubbles unless pause or a row gap intervenes.
// Optional feature macro: STREAMER_ROW_GAP_EN inserts ROW_GAP idle cycles
// after every non-final row.
module frame_streamer
  import cnn_pkg::*;
#(
  parameter int  DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int  IN_CHANNEL = CNN_IN_CHANNEL,
  parameter int  IMG_WIDTH  = CNN_IMG_WIDTH,
  parameter int  IMG_HEIGHT = CNN_IMG_HEIGHT,
  parameter int  ROW_GAP    = 2,
  localparam int ADDR_W     = addr_w(IMG_WIDTH * IMG_HEIGHT),
  localparam int PIX_W      = IN_CHANNEL * DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              start,
  input  logic              pause,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              pixel_valid,
  output logic              frame_start,
  output logic              busy,
  output logic              done
);

  localparam int WORDS = IMG_WIDTH * IMG_HEIGHT;
  localparam int COL_W = addr_w(IMG_WIDTH);
  localparam int ROW_W = addr_w(IMG_HEIGHT);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  if (ROW_GAP < 0) begin : g_bad_row_gap
    $error("frame_streamer: ROW_GAP must be non-negative");
  end

`ifdef STREAMER_ROW_GAP_EN
  localparam bit   GAP_ON = (ROW_GAP > 0);
  localparam int   GAP_W  = addr_w(ROW_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(ROW_GAP - 1);
  logic [GAP_W-1:0] r_gap;
`endif

  streamer_state_t   r_state;
  streamer_state_t   w_next;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;
  logic              r_tail;   // every address of the frame has been issued
  logic              r_vld;    // RAM output holds a pixel of this frame
  logic              w_issue;  // present r_addr to the RAM this cycle
  logic              w_last_col;
  logic              w_last_row;
  logic              w_we;
  logic [PIX_W-1:0]  w_ram_q;

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, read issue and status outputs.
  always_comb begin
    w_next      = r_state;
    w_issue     = 1'b0;
    busy        = (r_state != ST_IDLE);
    frame_start = (r_state == ST_SOF);
    done        = (r_state == ST_DONE);
    w_last_col  = (r_col == LAST_COL);
    w_last_row  = (r_row == LAST_ROW);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_SOF;
        end
      end
      ST_SOF: begin
        // First address goes out here so pixel 0 lands right after SOF.
        w_issue = 1'b1;
        w_next  = ST_STREAM;
      end
      ST_STREAM: begin
        // Once all addresses are out, this cycle shows the last pixel.
        if (r_tail) begin
          w_next = ST_DONE;
        end else if (!pause) begin
          w_issue = 1'b1;
        end
      end
`ifdef STREAMER_ROW_GAP_EN
      ST_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_next = ST_STREAM;
        end
      end
`endif
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
`ifdef STREAMER_ROW_GAP_EN
    if (GAP_ON && w_issue && w_last_col && !w_last_row) begin
      w_next = ST_GAP;
    end
`endif
  end

  // Raster counters and pixel-valid pipeline; cleared while idle so every
  // frame starts at address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
      r_tail <= 1'b0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= w_issue;
      if (r_state == ST_IDLE) begin
        r_col  <= '0;
        r_row  <= '0;
        r_addr <= '0;
        r_tail <= 1'b0;
      end else if (w_issue) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row  <= '0;
            r_tail <= 1'b1;
          end else begin
            r_row <= r_row + ROW_W'(1);
          end
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

`ifdef STREAMER_ROW_GAP_EN
  // Counts idle cycles spent between rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap <= '0;
    end else if (r_state == ST_GAP) begin
      r_gap <= r_gap + GAP_W'(1);
    end else begin
      r_gap <= '0;
    end
  end
`endif

  // The frame buffer only accepts writes while no frame is being streamed.
  assign w_we = wr_en && (r_state == ST_IDLE);

  frame_ram #(
    .WORDS  (WORDS),
    .WIDTH  (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_re    (w_issue),
    .i_raddr (r_addr),
    .o_rdata (w_ram_q)
  );

  // RAM data is not reset, so the output is gated by the reset valid flag.
  assign pixel_valid = r_vld;
  assign pixel_out   = r_vld ? w_ram_q : '0;

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: randomized and directed stimulus against an
// output-slot reference model of the frame streamer (4x4, 3x8-bit pixels).
module tb_frame_streamer;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int N  = IW * IH;
  localparam int AW = 4;
  localparam int PW = DW * CH;
`ifdef STREAMER_ROW_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [PW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [PW-1:0] pixel_out;
  logic          pixel_valid;
  logic          frame_start;
  logic          busy;
  logic          done;

  logic [PW-1:0] mem_m [N];
  int            n_total = 0;
  int            n_bad = 0;
  int            d;

  frame_streamer #(
    .DATA_WIDTH (DW),
    .IN_CHANNEL (CH),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH),
    .ROW_GAP    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .pause       (pause),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_out(input logic ev, input logic [PW-1:0] ep, input logic efs,
                         input logic ebusy, input logic edone);
    chk("pixel_valid", pixel_valid, ev);
    chk("pixel_out", pixel_out, ep);
    chk("frame_start", frame_start, efs);
    chk("busy", busy, ebusy);
    chk("done", done, edone);
  endtask

  task automatic step_begin();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic idle_cycle();
    step_begin();
    @(negedge clk);
    chk_out(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_word(input int a, input logic [PW-1:0] v);
    step_begin();
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = v;
    mem_m[a] = v;
    @(negedge clk);
    chk_out(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Writes attempted while a frame runs; the model memory is left alone.
  task automatic busy_write(input bit en);
    if (en && ($urandom_range(0, 1) == 1)) begin
      wr_en   = 1'b1;
      wr_addr = AW'($urandom_range(0, N - 1));
      wr_data = PW'($urandom);
    end
  endtask

  // One frame from the start cycle T through the done cycle.
  // pmode: 0 no pause, 1 random pause (ppct percent), 2 three pause cycles
  // beginning with the cycle that shows the fifth pixel.
  task automatic run_frame(input int pmode, input int ppct, input bit hold,
                           input bit wbusy, input bit wstart, input int abort_at,
                           output int done_ofs);
    int k;
    int gap_left;
    int ofs;
    int prun;
    bit prev_pause;
    bit ev;
    logic [PW-1:0] ep;
    k = 0; gap_left = 0; ofs = 1; prun = 0; prev_pause = 1'b0; ev = 1'b0;
    ep = '0; done_ofs = -1;
    // cycle T: start request, optionally with a write that must land first
    step_begin();
    start = 1'b1;
    pause = 1'($urandom_range(0, 1));
    if (wstart) begin
      wr_en   = 1'b1;
      wr_addr = AW'($urandom_range(0, N - 1));
      wr_data = PW'($urandom);
      mem_m[wr_addr] = wr_data;
    end
    @(negedge clk);
    chk_out(1'b0, '0, 1'b0, 1'b0, 1'b0);
    // cycle T+1: frame marker, pause has no effect here
    step_begin();
    start = hold;
    pause = 1'($urandom_range(0, 1));
    if (wbusy) begin
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_data = '1;
    end
    @(negedge clk);
    chk_out(1'b0, '0, 1'b1, 1'b1, 1'b0);
    // output slots from T+2 until every pixel has been seen
    while (k < N) begin
      ofs++;
      if (ofs > 300) begin
        chk("frame_timeout", k, N);
        return;
      end
      step_begin();
      start = hold | 1'($urandom_range(0, 1));
      busy_write(wbusy);
      if (gap_left > 0) begin
        ev = 1'b0;
        gap_left--;
      end else if (prev_pause) begin
        ev = 1'b0;
      end else begin
        ev = 1'b1;
        ep = mem_m[k];
        k++;
        if ((k % IW) == 0 && k < N) gap_left = GAP;
      end
      if (pmode == 1) begin
        pause = ($urandom_range(0, 99) < ppct);
      end else if (pmode == 2) begin
        if (ev && k == 5) prun = 3;
        pause = (prun > 0);
        if (prun > 0) prun--;
      end
      prev_pause = pause;
      @(negedge clk);
      chk_out(ev, ev ? ep : '0, 1'b0, 1'b1, 1'b0);
      if (abort_at > 0 && ev && k == abort_at) begin
        #2;
        start = 1'b0;
        pause = 1'b0;
        wr_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_out(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    // done cycle
    ofs++;
    step_begin();
    start = hold | 1'($urandom_range(0, 1));
    pause = 1'($urandom_range(0, 1));
    busy_write(wbusy);
    @(negedge clk);
    chk_out(1'b0, '0, 1'b0, 1'b1, 1'b1);
    done_ofs = ofs;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1 chk_out(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < N; k++) begin
      write_word(k, {8'(k + 32), 8'(k + 16), 8'(k)});
    end

    // plain frame: pixels T+2..T+17, done at T+18 plus row gaps
    run_frame(0, 0, 1'b0, 1'b0, 1'b0, 0, d);
    chk("done_ofs_plain", d, 18 + GAP * (IH - 1));

    // three pause cycles after the fifth pixel delay done by three
    run_frame(2, 0, 1'b0, 1'b0, 1'b0, 0, d);
    chk("done_ofs_pause", d, 21 + GAP * (IH - 1));

    // writes while busy must not reach the RAM; next frame shows old data
    run_frame(0, 0, 1'b0, 1'b1, 1'b0, 0, d);
    run_frame(0, 0, 1'b0, 1'b0, 1'b0, 0, d);

    // reset after six pixels: no done, restart from address 0
    run_frame(0, 0, 1'b0, 1'b0, 1'b0, 6, d);
    for (int i = 0; i < 3; i++) idle_cycle();
    run_frame(0, 0, 1'b0, 1'b0, 1'b0, 0, d);
    chk("done_ofs_restart", d, 18 + GAP * (IH - 1));

    // start held high: back-to-back frames, one marker each
    run_frame(0, 0, 1'b1, 1'b0, 1'b0, 0, d);
    run_frame(0, 0, 1'b1, 1'b0, 1'b0, 0, d);
    idle_cycle();

    // write coinciding with start is visible to that frame
    run_frame(0, 0, 1'b0, 1'b0, 1'b1, 0, d);

    // randomized contents, pause, held start and busy writes
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++) write_word(k, PW'($urandom));
      run_frame(1, 30, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 0, d);
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
